// File: rtl/im_fetch_port.sv
// im_fetch_port: synchronous instruction memory with a valid/ready fetch
// channel, an OBUF_DEPTH-entry in-order response queue, a byte-enabled
// boot-load write port, address-error reporting and a pipeline flush.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready     response queue head handshake
//   rsp_data/rsp_err        head word (0 on error) and error flag
//   rsp_addr                byte address echoed with the head response
//   wr_en/wr_addr/wr_data   word write (aligned, in range, else dropped)
//   wr_be                   byte enables, bit 0 = lowest-address byte
//   flush                   drops the in-flight read and all queued responses
//
// Build option: define IM_BYTE_SWAP_EN to byte-reverse fetched words and
// write data/enables at the array boundary (big-endian image handling).
module im_fetch_port #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned OBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    rsp_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic                 flush
);
    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
    localparam logic [ADDR_W-1:0] WORDS_A  = ADDR_W'(WORDS);

    // Misaligned or beyond the last word.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a & OFF_MASK) != '0) || ((a >> OFF) >= WORDS_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF);
    endfunction

`ifdef IM_BYTE_SWAP_EN
    function automatic logic [WIDTH-1:0] swap_bytes(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            r[8*b +: 8] = d[8*(BYTES-1-b) +: 8];
        end
        return r;
    endfunction

    function automatic logic [BYTES-1:0] swap_be(input logic [BYTES-1:0] e);
        logic [BYTES-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            r[b] = e[BYTES-1-b];
        end
        return r;
    endfunction
`endif

    logic [WIDTH-1:0]  mem [WORDS];

    logic              accept;
    logic              pop;
    logic              push;
    logic              do_pop;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  wr_slot;

    logic              inf_valid;
    logic              inf_err;
    logic [ADDR_W-1:0] inf_addr;
    logic [WIDTH-1:0]  inf_data;

    logic [WIDTH-1:0]  q_data   [OBUF_DEPTH];
    logic              q_err    [OBUF_DEPTH];
    logic [ADDR_W-1:0] q_addr   [OBUF_DEPTH];
    logic [WIDTH-1:0]  q_data_n [OBUF_DEPTH];
    logic              q_err_n  [OBUF_DEPTH];
    logic [ADDR_W-1:0] q_addr_n [OBUF_DEPTH];

    logic              rd_bad;
    logic [IDX_W-1:0]  rd_idx;
    logic [WIDTH-1:0]  rd_raw;
    logic [WIDTH-1:0]  rd_word;
    logic              wr_bad;
    logic [IDX_W-1:0]  wr_idx;
    logic [WIDTH-1:0]  wr_data_m;
    logic [BYTES-1:0]  wr_be_m;

    assign rd_bad = addr_bad(req_addr);
    assign rd_idx = addr_idx(req_addr);
    assign rd_raw = mem[rd_idx];
    assign wr_bad = addr_bad(wr_addr);
    assign wr_idx = addr_idx(wr_addr);

`ifdef IM_BYTE_SWAP_EN
    assign rd_word   = swap_bytes(rd_raw);
    assign wr_data_m = swap_bytes(wr_data);
    assign wr_be_m   = swap_be(wr_be);
`else
    assign rd_word   = rd_raw;
    assign wr_data_m = wr_data;
    assign wr_be_m   = wr_be;
`endif

    // Ready looks through a same-cycle pop so a held rsp_ready sustains 1 fetch/cycle.
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = OCC_W'(count) + OCC_W'(inf_valid) - OCC_W'(pop);
    assign req_ready = !flush && (occ < OCC_W'(OBUF_DEPTH));
    assign accept    = req_valid && req_ready;

    // Flush freezes the queue contents so the visible head holds its last value.
    assign push   = inf_valid && !flush;
    assign do_pop = pop && !flush;

    assign rsp_data = q_data[0];
    assign rsp_err  = q_err[0];
    assign rsp_addr = q_addr[0];

    // Shift-down queue: entry 0 is the head; only valid entries shift.
    always_comb begin
        q_data_n = q_data;
        q_err_n  = q_err;
        q_addr_n = q_addr;
        wr_slot  = count - CNT_W'(do_pop);
        count_n  = count;
        if (do_pop) begin
            for (int unsigned i = 0; i + 1 < OBUF_DEPTH; i++) begin
                if (CNT_W'(i + 1) < count) begin
                    q_data_n[i] = q_data[i+1];
                    q_err_n[i]  = q_err[i+1];
                    q_addr_n[i] = q_addr[i+1];
                end
            end
        end
        if (push) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                if (CNT_W'(i) == wr_slot) begin
                    q_data_n[i] = inf_data;
                    q_err_n[i]  = inf_err;
                    q_addr_n[i] = inf_addr;
                end
            end
        end
        if (flush) begin
            count_n = '0;
        end else begin
            count_n = count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Control, in-flight tag and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rsp_valid <= 1'b0;
            inf_valid <= 1'b0;
            inf_err   <= 1'b0;
            inf_addr  <= '0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                q_data[i] <= '0;
                q_err[i]  <= 1'b0;
                q_addr[i] <= '0;
            end
        end else begin
            count     <= count_n;
            rsp_valid <= (count_n != '0);
            inf_valid <= accept;
            if (accept) begin
                inf_err  <= rd_bad;
                inf_addr <= req_addr;
            end
            q_data <= q_data_n;
            q_err  <= q_err_n;
            q_addr <= q_addr_n;
        end
    end

    // Array read and byte-masked write; the read samples pre-write contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            inf_data <= rd_bad ? '0 : rd_word;
        end
        if (wr_en && !wr_bad) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr_be_m[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data_m[8*b +: 8];
                end
            end
        end
    end

endmodule
